issue_pipe_reg: RTL and testbench
=================================

# issue_pipe_reg

Parametrised inter-stage pipeline register for the N-wide in-order issue datapath, placed between decode and execute. It replaces the fixed two-lane enable/clear register. It carries LANES lanes of opaque payload as one issue group and adds a valid/ready handshake with a one-group skid buffer. It also provides per-lane tail kill, global flush, per-lane sequence tagging and an occupancy count.

## Interface
- LANES, 2, issue width; 1..4.
- WIDTH, 256, payload bits per lane.
- SEQ_W, 8, sequence tag width per lane.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  LANES  per-lane valid of the incoming group.
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- in_ready  out  1  group accepted this cycle when high and in_valid != 0.
- out_valid  out  LANES  per-lane valid of the head group.
- out_data  out  LANES*WIDTH  head group payload.
- out_seq  out  LANES*SEQ_W  sequence tag of each head lane.
- out_ready  in  1  consumer takes the whole head group.
- flush  in  1  discard every held and incoming group.
- kill_mask  in  LANES  kill head lanes; lowest set bit i kills lanes i..LANES-1.
- occupancy  out  2  groups held (0, 1, 2).
- err_noncontig  out  1  one-cycle pulse: accepted in_valid was not a contiguous prefix from lane 0.

## Operation
- Storage: head entry (drives out_*) and skid entry. Each entry holds LANES valid bits, data, tags.
- Accept: in_fire = in_ready & (in_valid != 0). An all-zero in_valid is never a transfer.
- Lane masking: in_valid is masked to its contiguous prefix from lane 0 before storage. Example: LANES=4, in_valid 1011 stores 0011 and pulses err_noncontig.
- Drain: out_fire = out_ready & (out_valid != 0).
- Routing of an accepted group:
  - Head empty, or head firing with skid empty: group enters the head.
  - Otherwise: group enters the skid.
- Skid promotion: when the head fires or is emptied by kill while the skid is full, the skid moves to the head on the same edge and the skid empties.
- in_ready = skid empty, driven from a register (no combinational path from out_ready).
- Sequence tags: counter next_seq, reset 0. An accepted group gets lane i tag = next_seq + i (mod 2^SEQ_W) for each stored valid lane. next_seq advances by popcount(stored valid lanes) and wraps modulo 2^SEQ_W.
- kill_mask: with lowest set bit i, clears head out_valid[i..LANES-1] at the edge. Lanes below i are unchanged. Ignored on a cycle where out_fire is high. Never affects the skid. next_seq is not rewound.
- flush: highest priority. At the edge:
  - head and skid valids clear;
  - the same-cycle input is discarded and next_seq does not advance for it;
  - a same-cycle out_fire still counts as delivered;
  - next_seq is kept.
- Data/tags of invalid lanes are don't-care, except after reset, when they are 0.
- occupancy = (head valid != 0) + (skid valid != 0).

## Timing
- Reset values (async, while rst_n low):
  - out_valid 0, out_data 0, out_seq 0;
  - skid cleared;
  - next_seq 0, occupancy 0, err_noncontig 0;
  - in_ready 1 from the first edge after rst_n deasserts.
- Latency: a group accepted at edge t is on out_* from edge t; minimum 1 cycle from in to out.
- Throughput: one group per cycle when out_ready stays high.
- Backpressure: head full with out_ready low takes one more group into the skid. in_ready is 0 from the next cycle until the skid promotes.
- Simultaneous events:
  - in_fire and out_fire with skid empty: head is replaced, occupancy unchanged.
  - kill and out_fire together: kill is ignored.
  - flush with anything else: flush wins.
- Wrap-around: next_seq 2^SEQ_W-1 + 2 lanes gives tags {255, 0} for SEQ_W=8, then next_seq = 1.
- Reset asserted mid-operation: all state clears immediately; no partial group survives.

## Test plan
- Reset then stream: LANES=2. Send groups 11, 01, 11 with out_ready=1 -> out appears one cycle after each accept; tags {0,1}, {2}, {3,4}; occupancy stays ≤1.
- Backpressure: out_ready=0, send A then B -> A at head, B in skid, in_ready=0, occupancy=2. Raise out_ready -> A leaves, B promotes on the same edge, in_ready=1 one cycle later.
- Kill: head valid 11, kill_mask=10, out_ready=0 -> out_valid 01 next cycle. Same with kill_mask=01 and skid full -> skid promotes to the head on that edge.
- Flush under load: occupancy 2, flush together with in_valid=11 -> occupancy 0 next cycle, input dropped, next_seq unchanged.
- Non-contiguous input: LANES=4, in_valid 1101 -> out_valid 0001, err_noncontig pulses for 1 cycle, next_seq +1.
- Wrap and async reset: preset next_seq to 255 via 255 single-lane accepts, accept 11 -> tags {255, 0}. Drop rst_n mid-cycle with occupancy 2 -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/issue_pipe_reg.sv
// Decode-to-execute issue register: LANES-wide group with valid/ready handshake,
// one-group skid buffer, tail kill, flush, per-lane sequence tags and occupancy.
module issue_pipe_reg #(
  parameter int LANES = 2,
  parameter int WIDTH = 256,
  parameter int SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES*SEQ_W-1:0] out_seq,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic [LANES-1:0]       kill_mask,
  output logic [1:0]             occupancy,
  output logic                   err_noncontig
);

  logic [LANES-1:0]       head_valid_reg, head_valid_next;
  logic [LANES*WIDTH-1:0] head_data_reg, head_data_next;
  logic [LANES*SEQ_W-1:0] head_seq_reg, head_seq_next;
  logic [LANES-1:0]       skid_valid_reg, skid_valid_next;
  logic [LANES*WIDTH-1:0] skid_data_reg, skid_data_next;
  logic [LANES*SEQ_W-1:0] skid_seq_reg, skid_seq_next;
  logic [SEQ_W-1:0]       next_seq_reg, next_seq_next;
  logic                   in_ready_reg, in_ready_next;
  logic                   err_reg, err_next;

  logic [LANES-1:0]       prefix, keep, head_kept;
  logic [LANES*SEQ_W-1:0] new_seq;
  logic [SEQ_W-1:0]       pop;
  logic                   run_v, run_k;
  logic                   in_fire, out_fire, store, kill_en, head_free, skid_full;

  // prefix: contiguous valid lanes from lane 0; keep: lanes below the lowest kill bit
  always_comb begin
    prefix = '0;
    keep   = '0;
    pop    = '0;
    run_v  = 1'b1;
    run_k  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      run_v     = run_v & in_valid[i];
      prefix[i] = run_v;
      run_k     = run_k & ~kill_mask[i];
      keep[i]   = run_k;
      pop       = pop + SEQ_W'(run_v);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_tag
    assign new_seq[gi*SEQ_W +: SEQ_W] = next_seq_reg + SEQ_W'(gi);
  end

  assign in_fire   = in_ready_reg & (|in_valid);
  assign out_fire  = out_ready & (|head_valid_reg);
  assign store     = in_fire & (|prefix) & ~flush;
  assign kill_en   = (|kill_mask) & ~out_fire;
  assign head_kept = out_fire ? '0 : (kill_en ? (head_valid_reg & keep) : head_valid_reg);
  assign head_free = (head_kept == '0);
  assign skid_full = |skid_valid_reg;

  always_comb begin
    head_valid_next = head_kept;
    head_data_next  = head_data_reg;
    head_seq_next   = head_seq_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_seq_next   = skid_seq_reg;
    next_seq_next   = next_seq_reg;
    if (flush) begin
      head_valid_next = '0;
      skid_valid_next = '0;
    end else begin
      if (skid_full && head_free) begin
        head_valid_next = skid_valid_reg;
        head_data_next  = skid_data_reg;
        head_seq_next   = skid_seq_reg;
        skid_valid_next = '0;
      end
      // store only happens with the skid empty, since in_ready mirrors skid emptiness
      if (store) begin
        next_seq_next = next_seq_reg + pop;
        if (head_free) begin
          head_valid_next = prefix;
          head_data_next  = in_data;
          head_seq_next   = new_seq;
        end else begin
          skid_valid_next = prefix;
          skid_data_next  = in_data;
          skid_seq_next   = new_seq;
        end
      end
    end
    in_ready_next = ~(|skid_valid_next);
    err_next      = in_fire & ~flush & (prefix != in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= '0;
      head_data_reg  <= '0;
      head_seq_reg   <= '0;
      skid_valid_reg <= '0;
      skid_data_reg  <= '0;
      skid_seq_reg   <= '0;
      next_seq_reg   <= '0;
      in_ready_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
      head_seq_reg   <= head_seq_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_seq_reg   <= skid_seq_next;
      next_seq_reg   <= next_seq_next;
      in_ready_reg   <= in_ready_next;
      err_reg        <= err_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = head_valid_reg;
  assign out_data      = head_data_reg;
  assign out_seq       = head_seq_reg;
  assign err_noncontig = err_reg;
  assign occupancy     = 2'(|head_valid_reg) + 2'(|skid_valid_reg);

endmodule

// File: tb/tb_issue_pipe_reg.sv
// Scoreboard bench for issue_pipe_reg (4 lanes): queue of expected groups, head is q[0].
`timescale 1ns/1ps
module tb_issue_pipe_reg;
  localparam int L = 4;
  localparam int W = 16;
  localparam int S = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [L-1:0]   in_valid = '0;
  logic [L*W-1:0] in_data = '0;
  logic           in_ready;
  logic [L-1:0]   out_valid;
  logic [L*W-1:0] out_data;
  logic [L*S-1:0] out_seq;
  logic           out_ready = 1'b0;
  logic           flush = 1'b0;
  logic [L-1:0]   kill_mask = '0;
  logic [1:0]     occupancy;
  logic           err_noncontig;

  always #5 clk = ~clk;

  issue_pipe_reg #(.LANES(L), .WIDTH(W), .SEQ_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_seq(out_seq), .out_ready(out_ready),
    .flush(flush), .kill_mask(kill_mask), .occupancy(occupancy), .err_noncontig(err_noncontig)
  );

  typedef struct {
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    logic [L*S-1:0] s;
  } grp_t;

  grp_t       q[$];
  logic [S-1:0] nseq = '0;
  logic       ready_m = 1'b0;
  logic       err_m = 1'b0;
  int         pass = 0;
  int         tot = 0;

  function automatic logic [L*W-1:0] dmask(input logic [L-1:0] v);
    logic [L*W-1:0] r = '0;
    for (int i = 0; i < L; i++) r[i*W +: W] = {W{v[i]}};
    return r;
  endfunction

  function automatic logic [L*S-1:0] smask(input logic [L-1:0] v);
    logic [L*S-1:0] r = '0;
    for (int i = 0; i < L; i++) r[i*S +: S] = {S{v[i]}};
    return r;
  endfunction

  function automatic logic [L-1:0] exp_v();
    return (q.size() > 0) ? q[0].v : '0;
  endfunction

  function automatic logic [L*W-1:0] exp_d();
    return (q.size() > 0) ? (q[0].d & dmask(q[0].v)) : '0;
  endfunction

  function automatic logic [L*S-1:0] exp_s();
    return (q.size() > 0) ? (q[0].s & smask(q[0].v)) : '0;
  endfunction

  // Advance the reference model by one edge using the currently driven inputs, then clock.
  task automatic tick();
    logic         of, inf;
    logic [L-1:0] pm, kp;
    int           low, cnt;
    grp_t         g;
    of  = (q.size() > 0) && out_ready;
    inf = ready_m && (in_valid != '0);
    pm  = '0;
    cnt = 0;
    for (int i = 0; i < L; i++) begin
      if (in_valid[i] && (i == cnt)) cnt++;
    end
    for (int i = 0; i < cnt; i++) pm[i] = 1'b1;
    err_m = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (of) begin
        void'(q.pop_front());
      end else if (kill_mask != '0 && q.size() > 0) begin
        low = L;
        for (int i = L - 1; i >= 0; i--) if (kill_mask[i]) low = i;
        kp = '0;
        for (int i = 0; i < low; i++) kp[i] = 1'b1;
        q[0].v = q[0].v & kp;
        if (q[0].v == '0) void'(q.pop_front());
      end
      if (inf) begin
        err_m = (pm != in_valid);
        if (pm != '0) begin
          g.v = pm;
          g.d = in_data;
          g.s = '0;
          for (int i = 0; i < cnt; i++) g.s[i*S +: S] = nseq + S'(i);
          q.push_back(g);
          nseq = nseq + S'(cnt);
        end
      end
    end
    @(posedge clk);
    #1;
    ready_m = (q.size() < 2);
  endtask

  task automatic send(input logic [L-1:0] v);
    in_valid = v;
    in_data  = {$urandom, $urandom};
    tick();
    in_valid = '0;
  endtask

  task automatic test_reset();
    #23;
    tot++; if (out_valid !== '0) $display("FAIL reset_valid got %b want 0", out_valid); else pass++;
    tot++; if (out_data !== '0) $display("FAIL reset_data got %h want 0", out_data); else pass++;
    tot++; if (out_seq !== '0) $display("FAIL reset_seq got %h want 0", out_seq); else pass++;
    tot++; if (occupancy !== 2'd0 || err_noncontig !== 1'b0)
      $display("FAIL reset_occ_err got occ=%0d err=%b want 0/0", occupancy, err_noncontig); else pass++;
    rst_n = 1'b1;
    tick();
    tot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
  endtask

  task automatic test_stream();
    logic [L-1:0] pats[4] = '{4'b0011, 4'b0001, 4'b0011, 4'b1111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(pats[i]);
      tot++; if (out_valid !== exp_v()) $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, exp_v()); else pass++;
      tot++; if ((out_data & dmask(exp_v())) !== exp_d()) $display("FAIL stream_data[%0d] got %h want %h", i, out_data, exp_d()); else pass++;
      tot++; if ((out_seq & smask(exp_v())) !== exp_s()) $display("FAIL stream_seq[%0d] got %h want %h", i, out_seq, exp_s()); else pass++;
      tot++; if (occupancy > 2'd1) $display("FAIL stream_occ[%0d] got %0d want <=1", i, occupancy); else pass++;
      if (i == 0) begin
        tot++; if (out_seq[15:0] !== 16'h0100) $display("FAIL stream_first_tags got %h want 0100", out_seq[15:0]); else pass++;
      end
    end
    tick();
    tot++; if (occupancy !== 2'(q.size())) $display("FAIL stream_drain got %0d want %0d", occupancy, q.size()); else pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'b0011);
    send(4'b0001);
    tot++; if (in_ready !== 1'b0 || in_ready !== ready_m) $display("FAIL bp_in_ready got %b want 0", in_ready); else pass++;
    tot++; if (occupancy !== 2'd2) $display("FAIL bp_occ got %0d want 2", occupancy); else pass++;
    tot++; if (out_valid !== exp_v() || (out_seq & smask(exp_v())) !== exp_s())
      $display("FAIL bp_head got %b/%h want %b/%h", out_valid, out_seq, exp_v(), exp_s()); else pass++;
    out_ready = 1'b1;
    tick();
    tot++; if (out_valid !== exp_v() || (out_data & dmask(exp_v())) !== exp_d())
      $display("FAIL bp_promote got %b/%h want %b/%h", out_valid, out_data, exp_v(), exp_d()); else pass++;
    tot++; if (in_ready !== 1'b1 || occupancy !== 2'd1) $display("FAIL bp_release got rdy=%b occ=%0d want 1/1", in_ready, occupancy); else pass++;
    tick();
  endtask

  task automatic test_kill();
    out_ready = 1'b0;
    send(4'b0011);
    kill_mask = 4'b0010;
    tick();
    kill_mask = '0;
    tot++; if (out_valid !== 4'b0001 || out_valid !== exp_v()) $display("FAIL kill_tail got %b want 0001", out_valid); else pass++;
    send(4'b0011);
    kill_mask = 4'b0001;
    tick();
    kill_mask = '0;
    tot++; if (out_valid !== exp_v() || (out_seq & smask(exp_v())) !== exp_s())
      $display("FAIL kill_promote got %b/%h want %b/%h", out_valid, out_seq, exp_v(), exp_s()); else pass++;
    tot++; if (occupancy !== 2'd1) $display("FAIL kill_occ got %0d want 1", occupancy); else pass++;
    send(4'b0011);
    out_ready = 1'b1;
    kill_mask = 4'b0001;
    tick();
    kill_mask = '0;
    tot++; if (out_valid !== 4'b0011 || out_valid !== exp_v()) $display("FAIL kill_ignored got %b want 0011", out_valid); else pass++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(4'b0011);
    send(4'b0011);
    flush = 1'b1;
    send(4'b0011);
    flush = 1'b0;
    tot++; if (occupancy !== 2'd0 || out_valid !== '0) $display("FAIL flush_full got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass++;
    send(4'b0001);
    flush = 1'b1;
    send(4'b0011);
    flush = 1'b0;
    tot++; if (occupancy !== 2'd0) $display("FAIL flush_one got %0d want 0", occupancy); else pass++;
    out_ready = 1'b1;
    send(4'b0001);
    tot++; if ((out_seq & smask(exp_v())) !== exp_s() || out_valid !== exp_v())
      $display("FAIL flush_seq_kept got %h want %h", out_seq, exp_s()); else pass++;
    tick();
  endtask

  task automatic test_noncontig();
    logic [L-1:0] pats[2] = '{4'b1101, 4'b1011};
    logic [L-1:0] want[2] = '{4'b0001, 4'b0011};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(pats[i]);
      tot++; if (out_valid !== want[i] || out_valid !== exp_v()) $display("FAIL nc_valid[%0d] got %b want %b", i, out_valid, want[i]); else pass++;
      tot++; if (err_noncontig !== 1'b1 || err_noncontig !== err_m) $display("FAIL nc_err_pulse[%0d] got %b want 1", i, err_noncontig); else pass++;
      tot++; if ((out_seq & smask(exp_v())) !== exp_s()) $display("FAIL nc_seq[%0d] got %h want %h", i, out_seq, exp_s()); else pass++;
      tick();
      tot++; if (err_noncontig !== 1'b0) $display("FAIL nc_err_clear[%0d] got %b want 0", i, err_noncontig); else pass++;
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int n = 0; n < 300 && nseq != 8'd255; n++) send(4'b0001);
    send(4'b0011);
    tot++; if (out_seq[15:0] !== 16'h00FF || out_valid !== 4'b0011) $display("FAIL wrap_tags got %h/%b want 00ff/0011", out_seq[15:0], out_valid); else pass++;
    send(4'b0001);
    tot++; if (out_seq[7:0] !== 8'd1) $display("FAIL wrap_next got %0d want 1", out_seq[7:0]); else pass++;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(4'b0011);
    send(4'b1111);
    #3;
    rst_n = 1'b0;
    #1;
    tot++; if (out_valid !== '0 || out_data !== '0 || out_seq !== '0)
      $display("FAIL areset_out got %b/%h/%h want 0", out_valid, out_data, out_seq); else pass++;
    tot++; if (occupancy !== 2'd0 || in_ready !== 1'b0) $display("FAIL areset_occ got occ=%0d rdy=%b want 0/0", occupancy, in_ready); else pass++;
    q.delete();
    nseq = '0;
    ready_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tot++; if (in_ready !== 1'b1) $display("FAIL areset_ready got %b want 1", in_ready); else pass++;
    out_ready = 1'b1;
    send(4'b0011);
    tot++; if (out_seq[15:0] !== 16'h0100) $display("FAIL areset_seq got %h want 0100", out_seq[15:0]); else pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_flush();
    test_noncontig();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
